instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DWIDTH, default 32: address and instruction width.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 fetch_en  input  1  global fetch enable from core control.
REQ-005 pc_value  input  DWIDTH  current PC from the PC controller.
REQ-006 pc_en  output  1  one-cycle pulse that advances the PC controller.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  DWIDTH  instruction-memory byte address.
REQ-009 imem_ack  input  1  memory response valid; one cycle per request.
REQ-010 imem_rdata  input  DWIDTH  instruction word, valid only when imem_ack=1.
REQ-011 flush  input  1  redirect: discard any held or in-flight fetch.
REQ-012 if_valid  output  1  fetched instruction valid toward decode.
REQ-013 if_ready  input  1  decode accepts the instruction.
REQ-014 if_instr  output  DWIDTH  fetched instruction.
REQ-015 if_pc  output  DWIDTH  address of if_instr; drives the PC controller's pc_in.
REQ-016 fetch_err  output  1  sticky misaligned-PC error flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, HOLD, STEP and DRAIN, and all outputs SHALL be registered.
REQ-018 IDLE: if fetch_en=1 and pc_value[1:0]=00, then at the next edge imem_req=1, imem_addr=pc_value, and the state goes to REQ.
REQ-019 IDLE: if fetch_en=1 and pc_value[1:0]!=00, no request is issued, fetch_err is set to 1, and the state stays IDLE.
REQ-020 fetch_err SHALL remain set until reset.
REQ-021 REQ: imem_req and imem_addr SHALL hold stable until imem_ack=1 is sampled; requests SHALL NOT be withdrawn.
REQ-022 REQ with imem_ack=1 and flush=0: the block latches if_instr=imem_rdata and if_pc=imem_addr, sets if_valid=1 and imem_req=0, and goes to HOLD.
REQ-023 REQ with flush=1 and imem_ack=0: the state goes to DRAIN and imem_req stays high.
REQ-024 REQ with flush=1 and imem_ack=1: the data is discarded, imem_req=0, and the state goes to IDLE.
REQ-025 HOLD: if_valid, if_instr and if_pc SHALL be held stable while if_ready=0.
REQ-026 HOLD with if_valid and if_ready both 1 and flush=0: if_valid clears, pc_en=1, and the state goes to STEP.
REQ-027 HOLD with flush=1: if_valid clears and the state goes to IDLE with no pc_en pulse; flush wins over a same-cycle if_ready.
REQ-028 STEP: lasts exactly one cycle, clears pc_en, and returns to IDLE; no request is issued in STEP.
- This guarantees IDLE samples the updated pc_value.
REQ-029 DRAIN: holds imem_req and imem_addr until imem_ack=1, discards that data, clears imem_req, and goes to IDLE.
- Further flush pulses in DRAIN are ignored.
REQ-030 fetch_en=0 SHALL only block new requests from IDLE; REQ, HOLD, STEP and DRAIN complete normally.
REQ-031 With a zero-wait memory (ack in the cycle after req rises) and if_ready=1, the loop SHALL be 4 cycles per instruction: IDLE, REQ, HOLD, STEP.
REQ-032 pc_en SHALL never be high for more than one consecutive cycle.
REQ-033 imem_ack sampled in IDLE, HOLD or STEP SHALL be ignored.
REQ-034 No address arithmetic is performed here; if_pc is a straight copy of the issued address (DWIDTH bits, no wrap logic).

Reset
REQ-035 reset=0 SHALL asynchronously force state=IDLE and pc_en=0, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0.
REQ-036 Reset asserted mid-request SHALL drop imem_req immediately; a late imem_ack after reset release SHALL be ignored per REQ-033.

Verification
REQ-037 Basic fetch: pc_value=0x0, fetch_en=1, ack next cycle with rdata=0x00500093, if_ready=1 -> if_instr=0x00500093, if_pc=0x0, and a single pc_en pulse 4 cycles after start.
REQ-038 Backpressure: if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc stay constant and there is no pc_en until the ready cycle.
REQ-039 Flush in flight: flush in REQ, ack 3 cycles later with 0xDEADBEEF -> DRAIN entered, if_valid never rises, and the next request uses the new pc_value=0x100.
REQ-040 Flush with ready: flush=1 and if_ready=1 in the same HOLD cycle -> if_valid=0, pc_en=0, state IDLE.
REQ-041 Misaligned PC: pc_value=0x102 with fetch_en=1 -> imem_req stays 0 and fetch_err=1 until reset.
REQ-042 Reset during REQ: reset=0 in REQ -> imem_req=0 immediately; an ack delivered after release produces if_valid=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM between PC controller, instruction memory and decode
//   clk, reset (async, active-low) | fetch_en, pc_value -> pc_en | imem_req/imem_addr <- imem_ack/imem_rdata
//   flush | if_valid/if_instr/if_pc -> decode, if_ready <- decode | fetch_err sticky misaligned-PC flag
module instr_fetch #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [DWIDTH-1:0] pc_value,
  output logic              pc_en,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DWIDTH-1:0] imem_rdata,
  input  logic              flush,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DWIDTH-1:0] if_instr,
  output logic [DWIDTH-1:0] if_pc,
  output logic              fetch_err
);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, STEP, DRAIN} state_t;
  state_t state;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc_en     <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (fetch_en) begin
            if (pc_value[1:0] == 2'b00) begin
              imem_req  <= 1'b1;
              imem_addr <= pc_value;
              state     <= REQ;
            end else begin
              fetch_err <= 1'b1;
            end
          end
        REQ:
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= flush ? IDLE : HOLD;
            if (!flush) begin
              if_instr <= imem_rdata;
              if_pc    <= imem_addr;
              if_valid <= 1'b1;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        HOLD:
          if (flush) begin
            if_valid <= 1'b0;
            state    <= IDLE;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            pc_en    <= 1'b1;
            state    <= STEP;
          end
        STEP: begin
          pc_en <= 1'b0;
          state <= IDLE;
        end
        DRAIN:
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch with directed scenarios and a randomized fetch stream
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] pc_value = '0;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;
  int tests = 0;
  int fails = 0;

  instr_fetch #(.DWIDTH(32)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_value(pc_value), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .flush(flush), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fetch_en = 1'b0;
    flush = 1'b0;
    imem_ack = 1'b0;
    if_ready = 1'b0;
    pc_value = '0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fetch_en = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFFFFFF;
    if_ready = 1'b1;
    repeat (3) cyc();
    tests += 7;
    if (pc_en !== 1'b0) begin fails++; $display("FAIL reset_pc_en: got %b expected 0", pc_en); end
    if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
    if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr); end
    if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    if (if_instr !== 32'h0) begin fails++; $display("FAIL reset_if_instr: got %h expected 0", if_instr); end
    if (if_pc !== 32'h0) begin fails++; $display("FAIL reset_if_pc: got %h expected 0", if_pc); end
    if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err); end
  endtask

  task automatic test_basic();
    do_reset();
    fetch_en = 1'b1;
    pc_value = 32'h0;
    if_ready = 1'b1;
    cyc();
    tests += 2;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL basic_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h0) begin fails++; $display("FAIL basic_addr: got %h expected 0", imem_addr); end
    imem_ack = 1'b1;
    imem_rdata = 32'h00500093;
    cyc();
    imem_ack = 1'b0;
    imem_rdata = 32'h12345678;
    tests += 5;
    if (if_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", if_valid); end
    if (if_instr !== 32'h00500093) begin fails++; $display("FAIL basic_instr: got %h expected 00500093", if_instr); end
    if (if_pc !== 32'h0) begin fails++; $display("FAIL basic_pc: got %h expected 0", if_pc); end
    if (imem_req !== 1'b0) begin fails++; $display("FAIL basic_req_drop: got %b expected 0", imem_req); end
    if (pc_en !== 1'b0) begin fails++; $display("FAIL basic_pc_en_early: got %b expected 0", pc_en); end
    cyc();
    tests += 2;
    if (pc_en !== 1'b1) begin fails++; $display("FAIL basic_pc_en: got %b expected 1", pc_en); end
    if (if_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_clear: got %b expected 0", if_valid); end
    pc_value = 32'h4;
    cyc();
    tests += 2;
    if (pc_en !== 1'b0) begin fails++; $display("FAIL basic_pc_en_pulse: got %b expected 0", pc_en); end
    if (imem_req !== 1'b0) begin fails++; $display("FAIL basic_no_req_step: got %b expected 0", imem_req); end
    cyc();
    tests += 2;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL basic_loop_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h4) begin fails++; $display("FAIL basic_loop_addr: got %h expected 4", imem_addr); end
    fetch_en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    r = $urandom;
    do_reset();
    fetch_en = 1'b1;
    pc_value = 32'h40;
    cyc();
    imem_ack = 1'b1;
    imem_rdata = r;
    cyc();
    imem_ack = 1'b0;
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_rdata = $urandom;
      tests += 4;
      if (if_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, if_valid); end
      if (if_instr !== r) begin fails++; $display("FAIL bp_instr[%0d]: got %h expected %h", i, if_instr, r); end
      if (if_pc !== 32'h40) begin fails++; $display("FAIL bp_pc[%0d]: got %h expected 40", i, if_pc); end
      if (pc_en !== 1'b0) begin fails++; $display("FAIL bp_pc_en[%0d]: got %b expected 0", i, pc_en); end
      if (i < 4) cyc();
    end
    if_ready = 1'b1;
    cyc();
    tests += 2;
    if (pc_en !== 1'b1) begin fails++; $display("FAIL bp_pc_en_ready: got %b expected 1", pc_en); end
    if (if_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_clear: got %b expected 0", if_valid); end
    if_ready = 1'b0;
  endtask

  task automatic test_flush_inflight();
    do_reset();
    fetch_en = 1'b1;
    pc_value = 32'h80;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    pc_value = 32'h100;
    tests += 2;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL fl_drain_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h80) begin fails++; $display("FAIL fl_drain_addr: got %h expected 80", imem_addr); end
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      flush = 1'b0;
      tests += 3;
      if (imem_req !== 1'b1) begin fails++; $display("FAIL fl_hold_req[%0d]: got %b expected 1", i, imem_req); end
      if (imem_addr !== 32'h80) begin fails++; $display("FAIL fl_hold_addr[%0d]: got %h expected 80", i, imem_addr); end
      if (if_valid !== 1'b0) begin fails++; $display("FAIL fl_valid[%0d]: got %b expected 0", i, if_valid); end
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    cyc();
    imem_ack = 1'b0;
    tests += 2;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL fl_ack_drop: got %b expected 0", imem_req); end
    if (if_valid !== 1'b0) begin fails++; $display("FAIL fl_discard: got %b expected 0", if_valid); end
    cyc();
    tests += 3;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL fl_new_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h100) begin fails++; $display("FAIL fl_new_addr: got %h expected 100", imem_addr); end
    if (if_valid !== 1'b0) begin fails++; $display("FAIL fl_new_valid: got %b expected 0", if_valid); end
    fetch_en = 1'b0;
  endtask

  task automatic test_flush_ready();
    do_reset();
    fetch_en = 1'b1;
    pc_value = 32'h10;
    cyc();
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    cyc();
    imem_ack = 1'b0;
    fetch_en = 1'b0;
    flush = 1'b1;
    if_ready = 1'b1;
    cyc();
    flush = 1'b0;
    if_ready = 1'b0;
    fetch_en = 1'b1;
    pc_value = 32'h20;
    tests += 2;
    if (if_valid !== 1'b0) begin fails++; $display("FAIL fr_valid: got %b expected 0", if_valid); end
    if (pc_en !== 1'b0) begin fails++; $display("FAIL fr_pc_en: got %b expected 0", pc_en); end
    cyc();
    tests += 3;
    if (pc_en !== 1'b0) begin fails++; $display("FAIL fr_pc_en_late: got %b expected 0", pc_en); end
    if (imem_req !== 1'b1) begin fails++; $display("FAIL fr_idle_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h20) begin fails++; $display("FAIL fr_idle_addr: got %h expected 20", imem_addr); end
    fetch_en = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    fetch_en = 1'b1;
    pc_value = 32'h102;
    for (int i = 0; i < 4; i++) begin
      cyc();
      tests += 2;
      if (imem_req !== 1'b0) begin fails++; $display("FAIL mis_req[%0d]: got %b expected 0", i, imem_req); end
      if (fetch_err !== 1'b1) begin fails++; $display("FAIL mis_err[%0d]: got %b expected 1", i, fetch_err); end
    end
    pc_value = 32'h104;
    cyc();
    tests += 3;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL mis_aligned_req: got %b expected 1", imem_req); end
    if (imem_addr !== 32'h104) begin fails++; $display("FAIL mis_aligned_addr: got %h expected 104", imem_addr); end
    if (fetch_err !== 1'b1) begin fails++; $display("FAIL mis_sticky: got %b expected 1", fetch_err); end
    do_reset();
    tests++;
    if (fetch_err !== 1'b0) begin fails++; $display("FAIL mis_reset_clear: got %b expected 0", fetch_err); end
  endtask

  task automatic test_reset_req();
    do_reset();
    fetch_en = 1'b1;
    pc_value = 32'h200;
    cyc();
    fetch_en = 1'b0;
    tests++;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL rr_req: got %b expected 1", imem_req); end
    reset = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL rr_async_drop: got %b expected 0", imem_req); end
    cyc();
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFEF00D;
    cyc();
    imem_ack = 1'b0;
    cyc();
    tests += 2;
    if (if_valid !== 1'b0) begin fails++; $display("FAIL rr_late_ack_valid: got %b expected 0", if_valid); end
    if (imem_req !== 1'b0) begin fails++; $display("FAIL rr_late_ack_req: got %b expected 0", imem_req); end
  endtask

  task automatic test_random_stream();
    logic [31:0] base, pc, exp_pc, req_addr;
    int accepted, wait_n, pulses;
    logic prev_pc_en, req_seen;
    do_reset();
    base = $urandom & 32'hFFFF_FFFC;
    pc = base;
    pc_value = pc;
    fetch_en = 1'b1;
    accepted = 0;
    pulses = 0;
    wait_n = -1;
    prev_pc_en = 1'b0;
    req_seen = 1'b0;
    req_addr = '0;
    for (int c = 0; c < 400; c++) begin
      cyc();
      if (pc_en) begin
        tests++;
        if (prev_pc_en !== 1'b0) begin fails++; $display("FAIL rs_pc_en_double: cycle %0d got 2 consecutive expected 1", c); end
        accepted++;
        pulses++;
        pc = pc + 32'd4;
        pc_value = pc;
      end
      exp_pc = base + 32'(accepted * 4);
      if (if_valid) begin
        tests++;
        if (if_instr !== mem_word(exp_pc) || if_pc !== exp_pc) begin
          fails++;
          $display("FAIL rs_deliver: cycle %0d got pc %h instr %h expected pc %h instr %h", c, if_pc, if_instr, exp_pc, mem_word(exp_pc));
        end
      end
      if (imem_req) begin
        tests++;
        if (!req_seen) begin
          req_seen = 1'b1;
          req_addr = imem_addr;
          if (imem_addr !== exp_pc) begin fails++; $display("FAIL rs_req_addr: cycle %0d got %h expected %h", c, imem_addr, exp_pc); end
        end else if (imem_addr !== req_addr) begin
          fails++;
          $display("FAIL rs_req_stable: cycle %0d got %h expected %h", c, imem_addr, req_addr);
        end
      end else begin
        req_seen = 1'b0;
      end
      prev_pc_en = pc_en;
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (wait_n < 0) wait_n = int'($urandom_range(0, 3));
        if (wait_n == 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_n = -1;
        end else begin
          wait_n--;
        end
      end
      if_ready = $urandom_range(0, 1) == 1;
    end
    fetch_en = 1'b0;
    imem_ack = 1'b0;
    tests++;
    if (accepted < 20) begin fails++; $display("FAIL rs_throughput: got %0d instructions expected at least 20", accepted); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_inflight();
    test_flush_ready();
    test_misaligned();
    test_reset_req();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
